// File: rtl/bus_router_pkg.sv
// bus_router_pkg
// Shared types and the default memory map for bus_router.
//   region_id_t   : id of a decoded region; DECODE_ERR_ID marks an unmapped access.
//   DEFAULT_*     : the stock map (main memory, I/O registers, palette, framebuffer).
//                   Region 0 sits in the LSBs of the packed arrays.
package bus_router_pkg;

    localparam int DEFAULT_NUM_REGIONS = 4;

    typedef logic [$clog2(DEFAULT_NUM_REGIONS+1)-1:0] region_id_t;

    localparam region_id_t DECODE_ERR_ID = region_id_t'(DEFAULT_NUM_REGIONS);

    localparam logic [31:0] MAIN_MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] IO_REG_BASE   = 32'hC000_0000;
    localparam logic [31:0] PALETTE_BASE  = 32'hC000_1000;
    localparam logic [31:0] FB_BASE       = 32'hC002_0000;

    localparam logic [5:0] MAIN_MEM_LOG2 = 6'd31;
    localparam logic [5:0] IO_REG_LOG2   = 6'd12;
    localparam logic [5:0] PALETTE_LOG2  = 6'd9;
    localparam logic [5:0] FB_LOG2       = 6'd17;

    localparam logic [3:0][31:0] DEFAULT_REGION_BASE =
        {FB_BASE, PALETTE_BASE, IO_REG_BASE, MAIN_MEM_BASE};
    localparam logic [3:0][5:0] DEFAULT_REGION_LOG2 =
        {FB_LOG2, PALETTE_LOG2, IO_REG_LOG2, MAIN_MEM_LOG2};

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO, no bypass: a push while full is ignored, a pop while
// empty is ignored. DEPTH must be a power of 2 so the pointers wrap freely.
//   clk, reset          : clock, synchronous active-high reset (clears pointers/count)
//   push, push_data     : write side
//   pop, pop_data       : read side; pop_data is the current head
//   full, empty         : occupancy flags
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & !full;
    assign do_pop   = pop & !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_router.sv
// bus_router
// Decodes one upstream load/store bus onto NUM_REGIONS targets. Reads are
// tracked in issue order by a FIFO of region ids; responses are taken only
// from the target at the FIFO head. Unmapped reads complete with data 0.
// Writes are posted and never enter the FIFO.
//   clk, reset                          : clock, synchronous active-high reset
//   req_valid/ready/addr/wr_en/wr_data  : upstream request (wr_en == 0 -> read)
//   rsp_valid/data/err                  : upstream read response, no back-pressure
//   t_req_valid/ready                   : per-target request handshake
//   t_addr/t_wr_en/t_wr_data            : shared request payload (t_addr = region offset)
//   t_rsp_valid/ready/data              : per-target read response handshake
//   fault_addr/fault_sticky             : last unmapped address / sticky flag
// Optional feature macro: BUS_ROUTER_ERR_EN adds the fault ports and drives
// rsp_err on unmapped reads; without it rsp_err is tied to 0.
module bus_router
    import bus_router_pkg::*;
#(
    parameter int NUM_REGIONS     = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_REGIONS-1:0][5:0]        REGION_LOG2 = DEFAULT_REGION_LOG2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W/8-1:0]           req_wr_en,
    input  logic [DATA_W-1:0]             req_wr_data,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_err,
    output logic [NUM_REGIONS-1:0]        t_req_valid,
    input  logic [NUM_REGIONS-1:0]        t_req_ready,
    output logic [ADDR_W-1:0]             t_addr,
    output logic [DATA_W/8-1:0]           t_wr_en,
    output logic [DATA_W-1:0]             t_wr_data,
    input  logic [NUM_REGIONS-1:0]        t_rsp_valid,
    output logic [NUM_REGIONS-1:0]        t_rsp_ready,
    input  logic [NUM_REGIONS*DATA_W-1:0] t_rsp_data
`ifdef BUS_ROUTER_ERR_EN
    ,
    output logic [ADDR_W-1:0]             fault_addr,
    output logic                          fault_sticky
`endif
);
    localparam int ID_W = $clog2(NUM_REGIONS+1);
    localparam logic [ID_W-1:0] UNMAPPED_ID = ID_W'(NUM_REGIONS);

    logic [NUM_REGIONS-1:0]             hit;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] offset;
    logic [ID_W-1:0]                    sel;
    logic                               mapped;
    logic                               tgt_rdy;
    logic                               is_read;
    logic                               accept;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic                               fifo_pop;
    logic [ID_W-1:0]                    head;

    // Region match compares only the bits above the region size, which is
    // the same as comparing the right-shifted address and base. A log2 of
    // ADDR_W or more yields an all-ones mask, i.e. the region covers all.
    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_dec
        localparam logic [ADDR_W-1:0] MASK = ~({ADDR_W{1'b1}} << REGION_LOG2[i]);
        assign hit[i]    = (req_addr & ~MASK) == (REGION_BASE[i] & ~MASK);
        assign offset[i] = req_addr & MASK;
        assign t_req_valid[i] = accept & (sel == ID_W'(i));
    end

    // Lowest index wins: scan downward so the last match kept is the lowest.
    always_comb begin
        sel = UNMAPPED_ID;
        for (int i = NUM_REGIONS-1; i >= 0; i--) begin
            if (hit[i]) sel = ID_W'(i);
        end
    end

    always_comb begin
        tgt_rdy = 1'b0;
        t_addr  = req_addr;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel == ID_W'(i)) begin
                tgt_rdy = t_req_ready[i];
                t_addr  = offset[i];
            end
        end
    end

    assign mapped    = (sel != UNMAPPED_ID);
    assign is_read   = (req_wr_en == '0);
    // Full blocks reads even if the head pops this cycle; writes never wait on it.
    assign req_ready = (is_read ? !fifo_full : 1'b1) & (!mapped | tgt_rdy);
    assign accept    = req_valid & req_ready;
    assign t_wr_en   = req_wr_en;
    assign t_wr_data = req_wr_data;

    sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept & is_read),
        .push_data (sel),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Only the head target may hand back data; everyone else is stalled.
    always_comb begin
        t_rsp_ready = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        fifo_pop    = 1'b0;
        if (!fifo_empty) begin
            if (head == UNMAPPED_ID) begin
                rsp_valid = 1'b1;
`ifdef BUS_ROUTER_ERR_EN
                rsp_err   = 1'b1;
`endif
                fifo_pop  = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (head == ID_W'(i)) begin
                        t_rsp_ready[i] = 1'b1;
                        rsp_valid      = t_rsp_valid[i];
                        rsp_data       = t_rsp_data[i*DATA_W +: DATA_W];
                        fifo_pop       = t_rsp_valid[i];
                    end
                end
            end
        end
    end

`ifdef BUS_ROUTER_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_addr   <= '0;
            fault_sticky <= 1'b0;
        end else if (accept && !mapped) begin
            fault_addr   <= req_addr;
            fault_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_router.sv
module tb_bus_router;
    localparam int NR = 4;

`ifdef BUS_ROUTER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [3:0]       req_wr_en;
    logic [31:0]      req_wr_data;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [NR-1:0]    t_req_valid;
    logic [NR-1:0]    t_req_ready;
    logic [31:0]      t_addr;
    logic [3:0]       t_wr_en;
    logic [31:0]      t_wr_data;
    logic [NR-1:0]    t_rsp_valid;
    logic [NR-1:0]    t_rsp_ready;
    logic [NR*32-1:0] t_rsp_data;
`ifdef BUS_ROUTER_ERR_EN
    logic [31:0]      fault_addr;
    logic             fault_sticky;
`endif

    bus_router dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wr_en   (req_wr_en),
        .req_wr_data (req_wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .t_req_valid (t_req_valid),
        .t_req_ready (t_req_ready),
        .t_addr      (t_addr),
        .t_wr_en     (t_wr_en),
        .t_wr_data   (t_wr_data),
        .t_rsp_valid (t_rsp_valid),
        .t_rsp_ready (t_rsp_ready),
        .t_rsp_data  (t_rsp_data)
`ifdef BUS_ROUTER_ERR_EN
        ,
        .fault_addr  (fault_addr),
        .fault_sticky(fault_sticky)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [32:0] sb [$];   // {err, data} in expected delivery order

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Response monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got data 0x%0h err %0b expected none", rsp_data, rsp_err);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                chk("rsp_err", 64'(rsp_err), 64'(e[32]));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input bit track, input logic [31:0] ed, input logic ee,
                          output bit ok);
        req_addr = a; req_wr_en = we; req_wr_data = wd; req_valid = 1'b1; ok = 1'b0;
        for (int k = 0; k < 16 && !ok; k++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1;
                if (we == 4'h0 && track) sb.push_back({ee, ed});
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; req_wr_en = 4'h0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  trdy;
        logic [3:0]  exp_tv;
        logic        exp_rdy;
        logic        chk_ta;
        logic [31:0] exp_ta;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bit ok;
        vecs[0]  = '{32'h0000_0010, 4'hF, 4'b0001, 1'b1, 1'b1, 32'h0000_0010};
        vecs[1]  = '{32'h7FFF_FFFC, 4'hF, 4'b0001, 1'b1, 1'b1, 32'h7FFF_FFFC};
        vecs[2]  = '{32'h0000_0010, 4'hE, 4'b0000, 1'b0, 1'b1, 32'h0000_0010};
        vecs[3]  = '{32'hC000_0ABC, 4'h2, 4'b0010, 1'b1, 1'b1, 32'h0000_0ABC};
        vecs[4]  = '{32'hC000_1004, 4'hF, 4'b0100, 1'b1, 1'b1, 32'h0000_0004};
        vecs[5]  = '{32'hC000_11FF, 4'hF, 4'b0100, 1'b1, 1'b1, 32'h0000_01FF};
        vecs[6]  = '{32'hC000_1004, 4'hB, 4'b0000, 1'b0, 1'b1, 32'h0000_0004};
        vecs[7]  = '{32'hC003_FFFC, 4'hF, 4'b1000, 1'b1, 1'b1, 32'h0001_FFFC};
        vecs[8]  = '{32'hC000_1200, 4'hF, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{32'hC004_0000, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{32'h8000_0000, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{32'hFFFF_FFFC, 4'hF, 4'b0000, 1'b1, 1'b0, 32'h0};

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr_en = '0; req_wr_data = '0;
        t_req_ready = '1; t_rsp_valid = '0; t_rsp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_t_rsp_ready", 64'(t_rsp_ready), 64'd0);
`ifdef BUS_ROUTER_ERR_EN
        chk("rst_fault_sticky", 64'(fault_sticky), 64'd0);
        chk("rst_fault_addr", 64'(fault_addr), 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // Decode table: writes presented combinationally, never accepted.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            t_req_ready = vecs[i].trdy;
            req_addr = vecs[i].addr; req_wr_en = 4'hF;
            req_wr_data = 32'hD000_0000 + 32'(i); req_valid = 1'b1;
            #1;
            chk($sformatf("dec%0d_t_req_valid", i), 64'(t_req_valid), 64'(vecs[i].exp_tv));
            chk($sformatf("dec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].exp_rdy));
            if (vecs[i].chk_ta) chk($sformatf("dec%0d_t_addr", i), 64'(t_addr), 64'(vecs[i].exp_ta));
            chk($sformatf("dec%0d_t_wr_data", i), 64'(t_wr_data), 64'(32'hD000_0000 + 32'(i)));
            chk($sformatf("dec%0d_t_wr_en", i), 64'(t_wr_en), 64'h F);
            req_valid = 1'b0; req_wr_en = 4'h0; t_req_ready = '1;
        end

        // Read to region 0, target answers 3 cycles after acceptance.
        @(posedge clk); #1;
        do_req(32'h0000_0010, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, ok);
        chk("rd0_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        t_rsp_valid[0] = 1'b1; t_rsp_data[31:0] = 32'h1234_5678;
        @(negedge clk);
        chk("rd0_t_rsp_ready", 64'(t_rsp_ready), 64'b0001);
        chk("rd0_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        t_rsp_valid[0] = 1'b0;
        @(negedge clk);
        chk("rd0_one_cycle", 64'(rsp_valid), 64'd0);

        // In-order: region 3 issued first, region 0 answers first and waits.
        @(posedge clk); #1;
        do_req(32'hC002_0010, 4'h0, 32'h0, 1'b1, 32'hBBBB_0003, 1'b0, ok);
        chk("ord_acc3", 64'(ok), 64'd1);
        do_req(32'h0000_0020, 4'h0, 32'h0, 1'b1, 32'hAAAA_0000, 1'b0, ok);
        chk("ord_acc0", 64'(ok), 64'd1);
        t_rsp_valid[0] = 1'b1; t_rsp_data[31:0] = 32'hAAAA_0000;
        repeat (2) begin
            @(negedge clk);
            chk("ord_stall_ready", 64'(t_rsp_ready), 64'b1000);
            chk("ord_stall_valid", 64'(rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        t_rsp_valid[3] = 1'b1; t_rsp_data[127:96] = 32'hBBBB_0003;
        @(posedge clk); #1;
        t_rsp_valid[3] = 1'b0;
        @(negedge clk);
        chk("ord_second_ready", 64'(t_rsp_ready), 64'b0001);
        @(posedge clk); #1;
        t_rsp_valid[0] = 1'b0;
        @(negedge clk);
        chk("ord_drained_valid", 64'(rsp_valid), 64'd0);
        chk("ord_drained_ready", 64'(t_rsp_ready), 64'd0);

        // Unmapped read: response one cycle after acceptance.
        @(posedge clk); #1;
        do_req(32'h8000_0000, 4'h0, 32'h0, 1'b1, 32'h0, ERR_EXP, ok);
        chk("unm_accept", 64'(ok), 64'd1);
        @(negedge clk);
        chk("unm_rsp_valid", 64'(rsp_valid), 64'd1);
`ifdef BUS_ROUTER_ERR_EN
        chk("unm_fault_addr", 64'(fault_addr), 64'h8000_0000);
        chk("unm_fault_sticky", 64'(fault_sticky), 64'd1);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("unm_popped", 64'(rsp_valid), 64'd0);

        // Fill to MAX_OUTSTANDING, then stall reads while writes still go.
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            do_req(32'h0000_0100 + 32'(4*k), 4'h0, 32'h0, 1'b1, 32'hA0 + 32'(k), 1'b0, ok);
            chk($sformatf("fill%0d_accept", k), 64'(ok), 64'd1);
        end
        req_addr = 32'h0000_0200; req_wr_en = 4'h0; req_valid = 1'b1;
        #1;
        chk("full_rd_stall", 64'(req_ready), 64'd0);
        req_wr_en = 4'hF; req_wr_data = 32'h5555_AAAA;
        #1;
        chk("full_wr_ready", 64'(req_ready), 64'd1);
        chk("full_wr_t_req_valid", 64'(t_req_valid), 64'b0001);
        @(posedge clk); #1;
        req_wr_en = 4'h0;
        t_rsp_valid[0] = 1'b1; t_rsp_data[31:0] = 32'hA0;
        #1;
        chk("full_pop_no_bypass", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        t_rsp_data[31:0] = 32'hA1;
        #1;
        chk("after_pop_ready", 64'(req_ready), 64'd1);
        if (req_ready) sb.push_back({1'b0, 32'hA4});
        @(posedge clk); #1;
        req_valid = 1'b0;
        t_rsp_data[31:0] = 32'hA2;
        @(posedge clk); #1;
        t_rsp_data[31:0] = 32'hA3;
        @(posedge clk); #1;
        t_rsp_data[31:0] = 32'hA4;
        @(posedge clk); #1;
        t_rsp_valid[0] = 1'b0;
        @(negedge clk);
        chk("fill_drained", 64'(rsp_valid), 64'd0);

        // Partial-strobe write held off by the target for two cycles.
        @(posedge clk); #1;
        t_req_ready = '0;
        req_addr = 32'hC000_1004; req_wr_en = 4'h3; req_wr_data = 32'h0000_BEEF; req_valid = 1'b1;
        #1;
        chk("wr_hold0_ready", 64'(req_ready), 64'd0);
        chk("wr_t_addr", 64'(t_addr), 64'h004);
        chk("wr_t_wr_en", 64'(t_wr_en), 64'h3);
        chk("wr_hold0_tv", 64'(t_req_valid), 64'd0);
        @(posedge clk); #1;
        chk("wr_hold1_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        t_req_ready = '1;
        #1;
        chk("wr_go_ready", 64'(req_ready), 64'd1);
        chk("wr_go_tv", 64'(t_req_valid), 64'b0100);
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr_en = 4'h0;
        @(negedge clk);
        chk("wr_no_push_valid", 64'(rsp_valid), 64'd0);
        chk("wr_no_push_ready", 64'(t_rsp_ready), 64'd0);

        // Reset with three reads outstanding (two stuck on region 0, one unmapped).
        @(posedge clk); #1;
        do_req(32'h0000_0300, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, ok);
        chk("rst_acc0", 64'(ok), 64'd1);
        do_req(32'h0000_0304, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, ok);
        chk("rst_acc1", 64'(ok), 64'd1);
        do_req(32'h9000_0004, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, ok);
        chk("rst_acc2", 64'(ok), 64'd1);
        @(negedge clk);
        chk("rst_pend_ready", 64'(t_rsp_ready), 64'b0001);
`ifdef BUS_ROUTER_ERR_EN
        chk("rst_pend_fault_addr", 64'(fault_addr), 64'h9000_0004);
        chk("rst_pend_sticky", 64'(fault_sticky), 64'd1);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_t_rsp_ready", 64'(t_rsp_ready), 64'd0);
`ifdef BUS_ROUTER_ERR_EN
        chk("mid_rst_sticky", 64'(fault_sticky), 64'd0);
`endif

        // Fresh read after reset: nothing stale ahead of it.
        @(posedge clk); #1;
        do_req(32'h0000_0044, 4'h0, 32'h0, 1'b1, 32'h0000_55AA, 1'b0, ok);
        chk("post_rst_accept", 64'(ok), 64'd1);
        t_rsp_valid[0] = 1'b1; t_rsp_data[31:0] = 32'h0000_55AA;
        @(negedge clk);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        t_rsp_valid[0] = 1'b0;
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
